matrix_multiplier_param: RTL and testbench
==========================================

# matrix_multiplier_param

Parametrised successor to the team's fixed 3x3 multiplier. It computes C = A x B for square N x N matrices. Operands are streamed in serially with a valid qualifier. The product is computed on a single time-shared MAC, and the result is streamed out with a valid/ready handshake. It sits between the byte-serial operand source and the result consumer, and replaces the fixed-size 8-bit block wherever a different size, width or signedness is needed.

## Interface
- N, default 3: matrix dimension (N >= 1).
- DW, default 8: operand width.
- SIGNED, default 0: 0 = unsigned operands, 1 = two's-complement operands and result.
- OW (localparam) = 2*DW + $clog2(N): result width, which is overflow-free for all operand values.
- clk  in  1  clock; all logic is on its rising edge.
- reset  in  1  synchronous active-high reset.
- start  in  1  begins a new operation; sampled only in IDLE.
- in_valid  in  1  qualifies `in` during LOAD.
- in  in  DW  operand element.
- out_ready  in  1  consumer accepts `o` this cycle.
- o  out  OW  result element.
- o_valid  out  1  `o` holds a valid result element.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final result is accepted.

## Operation
- States are IDLE, LOAD, CALC and OUT.
- IDLE -> LOAD on start=1.
- LOAD -> CALC after 2*N*N accepted elements.
- CALC -> OUT after N^3 MAC cycles.
- OUT -> IDLE after N*N handshakes.
- LOAD: each cycle with in_valid=1 writes `in` to the next slot.
  - The first N*N elements fill A, row-major (a[0][0], a[0][1], ...).
  - The next N*N elements fill B, row-major.
  - Cycles with in_valid=0 write nothing and do not advance the count.
  - in_valid is ignored outside LOAD, including in the start cycle.
- CALC: one multiply-accumulate per cycle, with loop order i (outer), j, k (inner).
  - At k=0: c[i][j] <= a[i][k]*b[k][j].
  - At k>0: c[i][j] <= c[i][j] + a[i][k]*b[k][j].
  - Each product is extended to OW bits: zero-extended when SIGNED=0, sign-extended when SIGNED=1.
  - Results never wrap.
- OUT: o = c[idx] and o_valid=1, where idx starts at 0 and runs row-major.
  - A handshake is o_valid & out_ready, and advances idx.
  - Without a handshake, o and idx hold.
  - After the handshake on idx = N*N-1: next state is IDLE and done=1 for that next cycle only.
- start while busy is ignored.
- The A, B and C storage is not cleared between operations. Every entry is rewritten before it is read, so stale data is never visible.

## Timing
- Reset values: state=IDLE, all counters 0, o=0, o_valid=0, busy=0, done=0.
- Reset clears the counters and state only; the array contents are don't-care.
- A reset asserted in any state returns the block to IDLE on the next edge. No done pulse and no further o_valid follow.
- busy rises the cycle after start is sampled.
- o is 0 whenever o_valid=0.
- Latency from start accepted to first o_valid is 1 + L + N^3 cycles, where L is the number of LOAD cycles (2*N*N when in_valid is held high).
  - For N=3 with no gaps: 1 + 18 + 27 = 46 cycles.
- With out_ready held high, the OUT phase takes N*N cycles. The done pulse is in the cycle after the last handshake, coincident with busy=0.
- The earliest back-to-back restart is a start sampled in the same cycle as done.
- Boundary case N=1: a single MAC in CALC, then one output.

## Test plan
- N=3, DW=8, unsigned. A = identity, B = 1..9, in_valid always high, out_ready always high -> o streams 1..9, first o_valid 46 cycles after start, done pulses once.
- N=3, all A and B elements = 255 -> all nine outputs = 195075 (18'h2FA03), with no truncation.
- SIGNED=1, N=2. A = [[-128,127],[1,-1]], B = [[-128,0],[1,1]] -> o = 16511, 127, -129, -1, in that order.
- in_valid toggled 1,0,1,0 during LOAD, then out_ready held low for 5 cycles on element 4 -> results unchanged, o stable while stalled, latency grows by exactly the gap and stall cycles.
- start pulsed during CALC -> ignored, and the current result completes normally.
- reset asserted for 1 cycle mid-CALC -> busy=0, o_valid=0 and done=0 next cycle. A fresh operation afterwards produces correct results.

Source files
------------

// File: rtl/matrix_multiplier_param.sv
// N x N matrix multiplier: operands streamed in serially, product computed on a
// single time-shared MAC (loop order i, j, k), results streamed out with valid/ready.
module matrix_multiplier_param #(
  parameter int N      = 3,
  parameter int DW     = 8,
  parameter int SIGNED = 0,
  localparam int OW    = 2*DW + $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in,
  input  logic          out_ready,
  output logic [OW-1:0] o,
  output logic          o_valid,
  output logic          busy,
  output logic          done
);

  localparam int NN = N*N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = (NN > 1) ? $clog2(NN) : 1;
  localparam int LW = $clog2(2*NN);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;

  state_t        r_state;
  logic [LW-1:0] r_ld;
  logic [CW-1:0] r_i, r_j, r_k;
  logic [AW-1:0] r_idx;
  logic [OW-1:0] r_o;
  logic          r_o_valid;
  logic          r_done;

  logic [DW-1:0] r_a [NN];
  logic [DW-1:0] r_b [NN];
  logic [OW-1:0] r_c [NN];

  logic          w_ld_fire, w_is_a;
  logic [AW-1:0] w_ld_idx, w_a_idx, w_b_idx, w_c_idx, w_idx_nxt;
  logic          w_i_last, w_j_last, w_k_last;
  logic [DW-1:0] w_a_op, w_b_op;
  logic [OW-1:0] w_a_ext, w_b_ext, w_prod, w_acc;

  assign w_ld_fire = (r_state == S_LOAD) && in_valid;
  assign w_is_a    = (r_ld < LW'(NN));
  assign w_ld_idx  = w_is_a ? AW'(r_ld) : AW'(r_ld - LW'(NN));

  assign w_a_idx   = AW'(int'(r_i) * N + int'(r_k));
  assign w_b_idx   = AW'(int'(r_k) * N + int'(r_j));
  assign w_c_idx   = AW'(int'(r_i) * N + int'(r_j));
  assign w_idx_nxt = r_idx + AW'(1);

  assign w_i_last  = (r_i == CW'(N-1));
  assign w_j_last  = (r_j == CW'(N-1));
  assign w_k_last  = (r_k == CW'(N-1));

  assign w_a_op    = r_a[w_a_idx];
  assign w_b_op    = r_b[w_b_idx];

  // Operands are widened to the full result width before multiplying, so the
  // product and every partial sum are exact in OW bits.
  if (SIGNED != 0) begin : g_signed
    assign w_a_ext = OW'($signed(w_a_op));
    assign w_b_ext = OW'($signed(w_b_op));
  end else begin : g_unsigned
    assign w_a_ext = OW'(w_a_op);
    assign w_b_ext = OW'(w_b_op);
  end

  assign w_prod = w_a_ext * w_b_ext;
  assign w_acc  = (r_k == '0) ? w_prod : r_c[w_c_idx] + w_prod;

  // NOTE: operand and result arrays have no reset; every entry is rewritten
  // before it is read, so clearing them would only cost logic.
  always_ff @(posedge clk) begin
    if (w_ld_fire) begin
      if (w_is_a) r_a[w_ld_idx] <= in;
      else        r_b[w_ld_idx] <= in;
    end
    if (r_state == S_CALC) r_c[w_c_idx] <= w_acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ld      <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_idx     <= '0;
      r_o       <= '0;
      r_o_valid <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_ld    <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (r_ld == LW'(2*NN-1)) begin
              r_state <= S_CALC;
              r_ld    <= '0;
              r_i     <= '0;
              r_j     <= '0;
              r_k     <= '0;
            end else begin
              r_ld <= r_ld + LW'(1);
            end
          end
        end
        S_CALC: begin
          if (w_k_last) begin
            r_k <= '0;
            if (w_j_last) begin
              r_j <= '0;
              if (w_i_last) begin
                r_i     <= '0;
                r_idx   <= '0;
                r_state <= S_OUT;
              end else begin
                r_i <= r_i + CW'(1);
              end
            end else begin
              r_j <= r_j + CW'(1);
            end
          end else begin
            r_k <= r_k + CW'(1);
          end
        end
        S_OUT: begin
          // First OUT cycle loads the output register; afterwards each
          // handshake presents the next element.
          if (!r_o_valid) begin
            r_o       <= r_c[r_idx];
            r_o_valid <= 1'b1;
          end else if (out_ready) begin
            if (r_idx == AW'(NN-1)) begin
              r_state   <= S_IDLE;
              r_idx     <= '0;
              r_o       <= '0;
              r_o_valid <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_idx <= w_idx_nxt;
              r_o   <= r_c[w_idx_nxt];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o       = r_o;
  assign o_valid = r_o_valid;
  assign done    = r_done;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_matrix_multiplier_param.sv
// Scoreboard bench for matrix_multiplier_param: three configurations (3x3 unsigned,
// 2x2 signed, 1x1 unsigned) checked against a plain-arithmetic matrix product.
module tb_matrix_multiplier_param;

  logic clk = 1'b0;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int N  = (g == 0) ? 3 : (g == 1) ? 2 : 1;
    localparam int DW = (g == 2) ? 4 : 8;
    localparam int SG = (g == 1) ? 1 : 0;
    localparam int OW = 2*DW + $clog2(N);
    localparam int NN = N*N;

    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic          out_ready = 1'b1;
    logic [OW-1:0] o;
    logic          o_valid, busy, done;

    logic [DW-1:0] mat_a [NN];
    logic [DW-1:0] mat_b [NN];
    logic [OW-1:0] exp_q [$];

    int            out_cnt = 0, done_cnt = 0, stall_cnt = 0;
    int            stall_at = -1, stall_until = 0;
    int            rise_cyc = 0, done_cyc = 0;
    bit            bp = 1'b0, fin = 1'b0;

    matrix_multiplier_param #(.N(N), .DW(DW), .SIGNED(SG)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_valid (in_valid),
      .in       (din),
      .out_ready(out_ready),
      .o        (o),
      .o_valid  (o_valid),
      .busy     (busy),
      .done     (done)
    );

    function automatic longint elem(input logic [DW-1:0] x);
      longint v = longint'(x);
      if (SG != 0 && x[DW-1]) v = v - (longint'(1) << DW);
      return v;
    endfunction

    task automatic push_model();
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          longint s = 0;
          for (int k = 0; k < N; k++) s += elem(mat_a[i*N+k]) * elem(mat_b[k*N+j]);
          exp_q.push_back(OW'(s));
        end
    endtask

    // mode 0 random, 1 identity x 1..NN, 2 all ones, 3 signed directed, 4 all MSB
    task automatic fill(input int mode);
      logic [7:0] da [4];
      logic [7:0] db [4];
      da = '{8'h80, 8'h7f, 8'h01, 8'hff};
      db = '{8'h80, 8'h00, 8'h01, 8'h01};
      for (int e = 0; e < NN; e++) begin
        case (mode)
          1: begin mat_a[e] = DW'((e / N == e % N) ? 1 : 0); mat_b[e] = DW'(e + 1); end
          2: begin mat_a[e] = '1; mat_b[e] = '1; end
          3: begin mat_a[e] = DW'(da[e % 4]); mat_b[e] = DW'(db[e % 4]); end
          4: begin mat_a[e] = DW'(1) << (DW-1); mat_b[e] = DW'(1) << (DW-1); end
          default: begin mat_a[e] = DW'($urandom); mat_b[e] = DW'($urandom); end
        endcase
      end
    endtask

    task automatic run_op(input bit gaps, input int stall_len, input bit bpi,
                          input bit calc_start, input bit calc_reset);
      int c0, lc, acc, base_out, base_done, w;
      bp = bpi;
      if (!calc_reset) push_model();
      base_out    = out_cnt;
      base_done   = done_cnt;
      stall_at    = (stall_len > 0) ? out_cnt + 4 : -1;
      stall_until = stall_cnt + stall_len;
      @(posedge clk); #1;
      start = 1'b1; in_valid = 1'b1; din = DW'($urandom);
      @(posedge clk); #1;
      c0 = cyc; start = 1'b0;
      check($sformatf("c%0d_busy_rise", g), busy, 1);
      lc = 0; acc = 0;
      while (acc < 2*NN) begin
        in_valid = !(gaps && lc < 4 && (lc % 2 == 1));
        din = in_valid ? ((acc < NN) ? mat_a[acc] : mat_b[acc-NN]) : DW'($urandom);
        @(posedge clk); #1;
        if (in_valid) acc++;
        lc++;
      end
      in_valid = 1'b1; din = DW'($urandom);
      if (calc_start) begin
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      if (calc_reset) begin
        repeat (NN) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check($sformatf("c%0d_rst_busy", g), busy, 0);
        check($sformatf("c%0d_rst_valid", g), o_valid, 0);
        check($sformatf("c%0d_rst_done", g), done, 0);
        repeat (N*N*N + NN + 8) @(posedge clk);
        check($sformatf("c%0d_rst_no_out", g), out_cnt - base_out, 0);
        check($sformatf("c%0d_rst_no_done", g), done_cnt - base_done, 0);
        return;
      end
      w = 0;
      while (done_cnt == base_done && w < 3000) begin
        @(posedge clk);
        w++;
      end
      check($sformatf("c%0d_done_seen", g), w < 3000, 1);
      repeat (2) @(negedge clk);
      check($sformatf("c%0d_done_pulses", g), done_cnt - base_done, 1);
      check($sformatf("c%0d_out_count", g), out_cnt - base_out, NN);
      check($sformatf("c%0d_queue_empty", g), exp_q.size(), 0);
      check($sformatf("c%0d_idle_busy", g), busy, 0);
      check($sformatf("c%0d_idle_o", g), o, 0);
      if (!bpi) begin
        check($sformatf("c%0d_latency", g), rise_cyc - c0, 1 + lc + N*N*N);
        check($sformatf("c%0d_done_time", g), done_cyc - c0, lc + N*N*N + NN + 1 + stall_len);
      end
      exp_q.delete();
    endtask

    // Monitor: chooses out_ready for the coming edge, then scores any handshake.
    initial begin
      bit            hold_flag = 1'b0;
      bit            prev_valid = 1'b0;
      logic [OW-1:0] hold_val = '0;
      forever begin
        @(negedge clk);
        if (hold_flag && o_valid) check($sformatf("c%0d_stall_hold", g), o, hold_val);
        hold_flag = 1'b0;
        if (o_valid && out_cnt == stall_at && stall_cnt < stall_until) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (o_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = o_valid;
        if (o_valid && out_ready) begin
          if (exp_q.size() == 0) check($sformatf("c%0d_unexpected_out", g), o_valid, 0);
          else check($sformatf("c%0d_out%0d", g, out_cnt), o, exp_q.pop_front());
          out_cnt++;
        end
        if (o_valid && !out_ready) begin
          hold_flag = 1'b1;
          hold_val  = o;
        end
        if (done) begin
          check($sformatf("c%0d_done_busy", g), busy, 0);
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end

    initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check($sformatf("c%0d_reset_valid", g), o_valid, 0);
      check($sformatf("c%0d_reset_busy", g), busy, 0);
      check($sformatf("c%0d_reset_done", g), done, 0);
      check($sformatf("c%0d_reset_o", g), o, 0);
      case (g)
        0: begin
          fill(1); run_op(0, 0, 0, 0, 0);
          fill(2); run_op(0, 0, 0, 0, 0);
          fill(0); run_op(1, 5, 0, 0, 0);
          fill(0); run_op(0, 0, 0, 1, 0);
          fill(0); run_op(0, 0, 0, 0, 1);
          fill(0); run_op(0, 0, 0, 0, 0);
          for (int r = 0; r < 3; r++) begin fill(0); run_op(r % 2, 0, 1, 0, 0); end
        end
        1: begin
          fill(3); run_op(0, 0, 0, 0, 0);
          fill(4); run_op(0, 0, 0, 0, 0);
          fill(2); run_op(1, 0, 0, 0, 0);
          for (int r = 0; r < 3; r++) begin fill(0); run_op(0, 0, 1, 0, 0); end
        end
        default: begin
          fill(2); run_op(0, 0, 0, 0, 0);
          fill(0); run_op(0, 0, 0, 0, 1);
          for (int r = 0; r < 3; r++) begin fill(0); run_op(r % 2, 0, r % 2, 0, 0); end
        end
      endcase
      fin = 1'b1;
    end
  end

  initial begin
    int w = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) && w < 60000) begin
      @(posedge clk);
      w++;
    end
    check("all_configs_finished", w < 60000, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
